// File: rtl/rsa_ctrl_pkg.sv
// Shared types and helpers for the RSA job arbiter.
package rsa_ctrl_pkg;

  typedef enum logic [2:0] {
    WAIT_CORE,
    ARB,
    START,
    BUSY_LO,
    BUSY_HI,
    RESP
  } ctrl_state_t;

  // Roughly 0.2 s at 100 MHz; long enough for a 2048-bit exponentiation.
  localparam logic [31:0] WDOG_DEFAULT = 32'd20000000;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester after ptr, wrapping.
module rr_arbiter
  import rsa_ctrl_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  input  logic            en,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  grant_idx,
  output logic            grant_any
);

  // Scan ptr+1 .. ptr+NREQ (mod NREQ) and take the first active request.
  always_comb begin
    int j;
    j         = 0;
    grant_idx = '0;
    grant_any = 1'b0;
    for (int off = 1; off <= NREQ; off++) begin
      j = (int'(ptr) + off) % NREQ;
      if (!grant_any && req[IDW'(j)]) begin
        grant_any = 1'b1;
        grant_idx = IDW'(j);
      end
    end
    grant = '0;
    for (int i = 0; i < NREQ; i++) begin
      grant[i] = en && grant_any && (grant_idx == IDW'(i));
    end
  end

endmodule

// File: rtl/rsa_job_arbiter.sv
// Shares one modular-exponentiation core between NREQ requesters.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// WAIT_CORE | core not ready (reset or still finishing), no grants
// ARB       | offer req_ready to the round-robin winner, latch its job
// START     | core_ds high for this single cycle
// BUSY_LO   | waiting for the core to drop core_ready (job accepted)
// BUSY_HI   | waiting for core_ready to return; capture cypher on rise
// RESP      | holding resp_* until the consumer takes it
module rsa_job_arbiter
  import rsa_ctrl_pkg::*;
#(
  parameter int          KEYSIZE     = 2048,
  parameter int          NREQ        = 4,
  parameter int          IDW         = clog2(NREQ),
  parameter logic [31:0] WDOG_CYCLES = WDOG_DEFAULT
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ*KEYSIZE-1:0] req_data,
  input  logic [NREQ*KEYSIZE-1:0] req_exp,
  input  logic [NREQ*KEYSIZE-1:0] req_mod,
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic [IDW-1:0]          resp_id,
  output logic [KEYSIZE-1:0]      resp_data,
  output logic                    resp_err,
  output logic [KEYSIZE-1:0]      core_indata,
  output logic [KEYSIZE-1:0]      core_exp,
  output logic [KEYSIZE-1:0]      core_mod,
  output logic                    core_ds,
  input  logic                    core_ready,
  input  logic [KEYSIZE-1:0]      core_cypher,
  output logic                    core_reset
);

  ctrl_state_t        state;
  logic [IDW-1:0]     rr_ptr;
  logic [31:0]        wdog_cnt;
  logic [NREQ-1:0]    grant;
  logic [IDW-1:0]     grant_idx;
  logic               grant_any;
  logic [KEYSIZE-1:0] sel_data, sel_exp, sel_mod;
  logic               busy, done, wdog_fire;

  rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_rr_arbiter (
    .req       (req_valid),
    .ptr       (rr_ptr),
    .en        (state == ARB),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_any (grant_any)
  );

  assign req_ready = grant;

  // Route the winning requester's operands to the latch inputs.
  always_comb begin
    sel_data = '0;
    sel_exp  = '0;
    sel_mod  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        sel_data = req_data[i*KEYSIZE +: KEYSIZE];
        sel_exp  = req_exp[i*KEYSIZE +: KEYSIZE];
        sel_mod  = req_mod[i*KEYSIZE +: KEYSIZE];
      end
    end
  end

  // Completion wins over a watchdog expiry landing in the same cycle.
  assign busy       = (state == BUSY_LO) || (state == BUSY_HI);
  assign done       = (state == BUSY_HI) && core_ready;
  assign wdog_fire  = busy && (wdog_cnt == '0) && !done;
  assign core_reset = reset || wdog_fire;

  // Job sequencing, operand latching and response registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= WAIT_CORE;
      rr_ptr      <= IDW'(NREQ - 1);
      wdog_cnt    <= '0;
      core_ds     <= 1'b0;
      core_indata <= '0;
      core_exp    <= '0;
      core_mod    <= '0;
      resp_valid  <= 1'b0;
      resp_err    <= 1'b0;
      resp_id     <= '0;
      resp_data   <= '0;
    end else begin
      core_ds <= 1'b0;
      case (state)
        WAIT_CORE: if (core_ready) state <= ARB;
        ARB: begin
          if (grant_any) begin
            core_indata <= sel_data;
            core_exp    <= sel_exp;
            core_mod    <= sel_mod;
            resp_id     <= grant_idx;
            rr_ptr      <= grant_idx;
            if (sel_mod == '0) begin
              resp_err   <= 1'b1;
              resp_data  <= '0;
              resp_valid <= 1'b1;
              state      <= RESP;
            end else begin
              core_ds <= 1'b1;
              state   <= START;
            end
          end
        end
        START: begin
          wdog_cnt <= WDOG_CYCLES - 32'd1;
          state    <= BUSY_LO;
        end
        BUSY_LO, BUSY_HI: begin
          wdog_cnt <= wdog_cnt - 32'd1;
          if (done) begin
            resp_data  <= core_cypher;
            resp_err   <= 1'b0;
            resp_valid <= 1'b1;
            state      <= RESP;
          end else if (wdog_fire) begin
            resp_data  <= '0;
            resp_err   <= 1'b1;
            resp_valid <= 1'b1;
            state      <= RESP;
          end else if ((state == BUSY_LO) && !core_ready) begin
            state <= BUSY_HI;
          end
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            state      <= core_ready ? ARB : WAIT_CORE;
          end
        end
        default: state <= WAIT_CORE;
      endcase
    end
  end

endmodule

// File: tb/tb_rsa_job_arbiter.sv
// Randomized bench for rsa_job_arbiter with a behavioural scoreboard.
module tb_rsa_job_arbiter;

  localparam int          K  = 16;
  localparam int          N  = 4;
  localparam int          IW = 2;
  localparam logic [31:0] WD = 32'd100;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*K-1:0] req_data, req_exp, req_mod;
  logic           resp_valid, resp_ready, resp_err;
  logic [IW-1:0]  resp_id;
  logic [K-1:0]   resp_data;
  logic [K-1:0]   core_indata, core_exp, core_mod, core_cypher;
  logic           core_ds, core_reset;
  logic           core_ready = 1'b0;

  rsa_job_arbiter #(.KEYSIZE(K), .NREQ(N), .IDW(IW), .WDOG_CYCLES(WD)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_data(req_data), .req_exp(req_exp), .req_mod(req_mod),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_data(resp_data), .resp_err(resp_err), .core_indata(core_indata),
    .core_exp(core_exp), .core_mod(core_mod), .core_ds(core_ds),
    .core_ready(core_ready), .core_cypher(core_cypher), .core_reset(core_reset)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, want);
    end
  endtask

  function automatic logic [K-1:0] modexp(input logic [K-1:0] b, input logic [K-1:0] e,
                                          input logic [K-1:0] m);
    longint unsigned r, x, mm;
    if (m == '0) return '0;
    mm = longint'(m);
    r  = 1 % mm;
    x  = longint'(b) % mm;
    for (int i = 0; i < K; i++) begin
      if (e[i]) r = (r * x) % mm;
      x = (x * x) % mm;
    end
    return K'(r);
  endfunction

  // Stimulus state
  logic [K-1:0] op_d[N], op_e[N], op_m[N];
  int  remaining[N];
  int  lat_req = 3;
  bit  hang_req = 0;
  bit  lat_rand = 0, rr_rand = 0, zero_ok = 0;
  int  stall = 0;
  int  xfer_done = 0;

  always_comb begin
    req_data = '0;
    req_exp  = '0;
    req_mod  = '0;
    for (int i = 0; i < N; i++) begin
      req_data[i*K +: K] = op_d[i];
      req_exp[i*K +: K]  = op_e[i];
      req_mod[i*K +: K]  = op_m[i];
    end
  end

  // Core model: ready 5 cycles after reset, busy lat_req cycles per job, can hang.
  int           cm_cnt = 0;
  bit           cm_hang = 0;
  logic [K-1:0] cm_res = '0;
  always @(posedge clk) begin
    if (core_reset) begin
      core_ready <= 1'b0;
      cm_cnt     <= 5;
      cm_hang    <= 1'b0;
    end else if (core_ready) begin
      if (core_ds) begin
        core_ready <= 1'b0;
        cm_cnt     <= lat_req;
        cm_hang    <= hang_req;
        cm_res     <= modexp(core_indata, core_exp, core_mod);
      end
    end else if (!cm_hang) begin
      if (cm_cnt <= 1) begin
        core_ready  <= 1'b1;
        core_cypher <= cm_res;
      end else begin
        cm_cnt <= cm_cnt - 1;
      end
    end
  end

  // Scoreboard: phase 0 = idle waiting core, 1 = may grant, 2 = job outstanding.
  typedef struct {
    int           id;
    logic [K-1:0] d, e, m, res;
    bit           err;
    int           ds;
  } job_t;

  job_t q[$];
  int   grant_log[$];
  int   ph = 0, ptr_m = N - 1, cyc = 0;
  int   ds_cyc = 0, ds_cnt = 0, ds_total = 0, wd_pulses = 0;
  int   hold = 0, max_hold = 0, resp_total = 0;
  int   xfer_seq = 0, xfer_id = 0;
  logic [K-1:0] last_data = '0;
  bit   last_err = 0;
  int   last_id = 0;

  always @(negedge clk) begin : mon
    int g;
    logic [N-1:0] exp_rdy;
    job_t j;
    cyc++;
    if (reset) begin
      ph = 0; ptr_m = N - 1; ds_cnt = 0; hold = 0;
      q.delete();
    end else begin
      g = -1;
      if (ph == 1) begin
        for (int off = 1; off <= N; off++) begin
          if (g < 0 && req_valid[IW'((ptr_m + off) % N)]) g = (ptr_m + off) % N;
        end
      end
      exp_rdy = (g >= 0) ? (N'(1) << g) : '0;
      chk("req_ready", 64'(req_ready), 64'(exp_rdy));
      if (g >= 0) begin
        j.id  = g;
        j.d   = op_d[g];
        j.e   = op_e[g];
        j.m   = op_m[g];
        j.err = (op_m[g] == '0) || hang_req;
        j.res = j.err ? '0 : modexp(op_d[g], op_e[g], op_m[g]);
        j.ds  = (op_m[g] == '0) ? 0 : 1;
        q.push_back(j);
        grant_log.push_back(g);
        ptr_m = g; ph = 2; ds_cnt = 0; hold = 0;
        xfer_id = g; xfer_seq++;
      end else if (ph == 0 && core_ready) begin
        ph = 1;
      end

      if (q.size() == 0) begin
        chk("ds_while_idle", 64'(core_ds), 64'd0);
      end else if (core_ds) begin
        ds_cnt++; ds_total++; ds_cyc = cyc;
        chk("ds_indata", 64'(core_indata), 64'(q[0].d));
        chk("ds_exp", 64'(core_exp), 64'(q[0].e));
        chk("ds_mod", 64'(core_mod), 64'(q[0].m));
      end

      if (core_reset) begin
        wd_pulses++;
        chk("wdog_delay", 64'(cyc - ds_cyc), 64'(WD));
      end

      if (q.size() == 0) begin
        chk("idle_resp_valid", 64'(resp_valid), 64'd0);
      end else if (resp_valid) begin
        hold++;
        chk("resp_id", 64'(resp_id), 64'(q[0].id));
        chk("resp_data", 64'(resp_data), 64'(q[0].res));
        chk("resp_err", 64'(resp_err), 64'(q[0].err));
        if (resp_ready) begin
          chk("ds_per_job", 64'(ds_cnt), 64'(q[0].ds));
          last_data = resp_data; last_err = resp_err; last_id = int'(resp_id);
          if (hold > max_hold) max_hold = hold;
          resp_total++;
          void'(q.pop_front());
          ph = core_ready ? 1 : 0;
        end
      end
    end
  end

  task automatic new_ops(input int i);
    op_d[i] = K'($urandom);
    op_e[i] = K'($urandom);
    if (zero_ok && $urandom_range(0, 7) == 0) op_m[i] = '0;
    else op_m[i] = K'($urandom_range(1, 65535));
  endtask

  task automatic submit(input int i, input int n);
    remaining[i] = n;
    new_ops(i);
    req_valid[IW'(i)] = 1'b1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (xfer_seq != xfer_done) begin
      xfer_done = xfer_seq;
      remaining[xfer_id]--;
      if (remaining[xfer_id] > 0) new_ops(xfer_id);
      else req_valid[IW'(xfer_id)] = 1'b0;
    end
    if (stall > 0) begin
      resp_ready = 1'b0;
      stall--;
    end else begin
      resp_ready = rr_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end
    if (lat_rand) lat_req = $urandom_range(1, 12);
  endtask

  task automatic drain(input string tag, input int budget);
    for (int c = 0; c < budget && !(q.size() == 0 && req_valid == '0); c++) step();
    chk(tag, 64'(q.size() == 0 && req_valid == '0), 64'd1);
  endtask

  task automatic wait_ds(input string tag, input int d0, input int budget);
    for (int c = 0; c < budget && ds_total == d0; c++) step();
    chk(tag, 64'(ds_total > d0), 64'd1);
  endtask

  task automatic apply_reset();
    reset     = 1'b1;
    req_valid = '0;
    for (int i = 0; i < N; i++) remaining[i] = 0;
    repeat (3) step();
    reset = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_req_ready"}, 64'(req_ready), 64'd0);
    chk({tag, "_resp_valid"}, 64'(resp_valid), 64'd0);
    chk({tag, "_resp_err"}, 64'(resp_err), 64'd0);
    chk({tag, "_resp_id"}, 64'(resp_id), 64'd0);
    chk({tag, "_resp_data"}, 64'(resp_data), 64'd0);
    chk({tag, "_core_ds"}, 64'(core_ds), 64'd0);
    chk({tag, "_core_indata"}, 64'(core_indata), 64'd0);
    chk({tag, "_core_exp"}, 64'(core_exp), 64'd0);
    chk({tag, "_core_mod"}, 64'(core_mod), 64'd0);
    chk({tag, "_core_reset"}, 64'(core_reset), 64'd0);
  endtask

  initial begin
    int base, d0, w0, r0;
    logic [K-1:0] sd, se, sm;
    reset      = 1'b1;
    req_valid  = '0;
    resp_ready = 1'b1;
    for (int i = 0; i < N; i++) begin
      op_d[i] = '0; op_e[i] = '0; op_m[i] = '0; remaining[i] = 0;
    end

    // Reset values, then 4^13 mod 497 from requester 0.
    apply_reset();
    @(negedge clk);
    check_reset_values("rst");
    step();
    submit(0, 1);
    op_d[0] = K'(4); op_e[0] = K'(13); op_m[0] = K'(497);
    drain("t1_drain", 200);
    chk("t1_result", 64'(last_data), 64'd445);
    chk("t1_id", 64'(last_id), 64'd0);
    chk("t1_err", 64'(last_err), 64'd0);
    chk("t1_ds_total", 64'(ds_total), 64'd1);

    // All requesters busy: fair rotation from a fresh pointer.
    apply_reset();
    base = grant_log.size();
    d0   = ds_total;
    lat_rand = 1;
    for (int i = 0; i < N; i++) submit(i, 2);
    drain("t2_drain", 2000);
    chk("t2_grants", 64'(grant_log.size() - base), 64'd8);
    for (int k = 0; k < 8 && base + k < grant_log.size(); k++)
      chk("t2_order", 64'(grant_log[base + k]), 64'(k % N));
    chk("t2_ds", 64'(ds_total - d0), 64'd8);
    lat_rand = 0;

    // Zero modulus rejected without touching the core.
    d0 = ds_total;
    submit(2, 1);
    op_m[2] = '0;
    drain("t3_drain", 200);
    chk("t3_err", 64'(last_err), 64'd1);
    chk("t3_data", 64'(last_data), 64'd0);
    chk("t3_id", 64'(last_id), 64'd2);
    chk("t3_no_ds", 64'(ds_total - d0), 64'd0);

    // Hung core: watchdog abort, then a normal job afterwards.
    w0 = wd_pulses;
    d0 = ds_total;
    hang_req = 1'b1;
    submit(1, 1);
    op_m[1] = K'(1234);
    wait_ds("t4_ds_seen", d0, 50);
    hang_req = 1'b0;
    drain("t4_drain", 400);
    chk("t4_err", 64'(last_err), 64'd1);
    chk("t4_data", 64'(last_data), 64'd0);
    chk("t4_pulses", 64'(wd_pulses - w0), 64'd1);
    submit(1, 1);
    if (op_m[1] == '0) op_m[1] = K'(999);
    sd = op_d[1]; se = op_e[1]; sm = op_m[1];
    drain("t4_recover_drain", 200);
    chk("t4_recover_err", 64'(last_err), 64'd0);
    chk("t4_recover_data", 64'(last_data), 64'(modexp(sd, se, sm)));

    // Consumer stalls; response must hold and no new grant may appear.
    max_hold = 0;
    stall = 60;
    submit(3, 1);
    submit(0, 1);
    drain("t5_drain", 400);
    chk("t5_hold_ge_50", 64'(max_hold >= 50), 64'd1);

    // Reset while the core is busy: job vanishes without a response.
    lat_req = 30;
    d0 = ds_total;
    submit(0, 1);
    wait_ds("t6_ds_seen", d0, 50);
    repeat (10) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    @(negedge clk);
    check_reset_values("t6");
    r0 = resp_total;
    repeat (40) step();
    chk("t6_no_resp", 64'(resp_total - r0), 64'd0);
    lat_req = 3;

    // Random traffic: mixed masks, zero moduli, random backpressure and latency.
    rr_rand = 1; lat_rand = 1; zero_ok = 1;
    for (int r = 0; r < 8; r++) begin
      int mask;
      mask = $urandom_range(1, (1 << N) - 1);
      for (int i = 0; i < N; i++)
        if (mask[i]) submit(i, $urandom_range(1, 3));
      if ($urandom_range(0, 3) == 0) stall = $urandom_range(5, 20);
      drain("t7_drain", 3000);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
